osc_ce_scheduler: RTL



---
 rtl/osc_ce_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/osc_ce_scheduler.sv
// ============================================================================
// Module      : osc_ce_scheduler
// Description : Generates NUM_CH independent single-cycle clock-enable strobes
//               on the internal-oscillator clock. Each channel has a
//               programmable divisor. All strobes are held off until an
//               oscillator settle period has elapsed. New divisors are staged
//               and applied only on period boundaries, so no short period or
//               glitch is ever produced.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1        oscillator clock
//   rst          in   1        synchronous reset, active-high
//   i_ch_en      in   NUM_CH   per-channel run gate
//   i_cfg_valid  in   1        divisor write request
//   o_cfg_ready  out  1        write accepted when i_cfg_valid && o_cfg_ready
//   i_cfg_ch     in   CH_W     target channel (>= NUM_CH accepted, ignored)
//   i_cfg_div    in   DIV_W    new divisor (0 = channel off)
//   i_sync_pulse in   1        phase-align all running channels
//                              (present only with OSC_CE_SYNC_EN)
//   o_osc_ready  out  1        settle period complete
//   o_ce_out     out  NUM_CH   registered one-cycle enable strobes
// Optional feature macro: OSC_CE_SYNC_EN (adds i_sync_pulse)
// ============================================================================
`default_nettype none

module osc_ce_scheduler #(
    parameter int NUM_CH        = 4,
    parameter int DIV_W         = 16,
    parameter int SETTLE_CYCLES = 1024,
    parameter int DEF_DIV       = 105,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [DIV_W-1:0]  i_cfg_div,
`ifdef OSC_CE_SYNC_EN
    input  logic              i_sync_pulse,
`endif
    output logic              o_osc_ready,
    output logic [NUM_CH-1:0] o_ce_out
);

    // Wide enough to hold SETTLE_CYCLES itself, so SETTLE_CYCLES=1 works too.
    localparam int             SET_W          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] c_settle_last = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SET_W-1:0]   r_settle;
    logic               w_run;
    logic               w_accept;
    logic               r_acc_d;
    logic               w_sync;

    // ------------------------------------------------------------------
    // Settle / run state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_SETTLE;
            r_settle <= '0;
            r_acc_d  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_SETTLE) begin
                r_settle <= r_settle + SET_W'(1);
            end
            r_acc_d <= w_accept;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_SETTLE: begin
                if (r_settle == c_settle_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = ST_SETTLE;
            end
        endcase
    end

    assign o_osc_ready = w_run;

    // One-entry staging per channel: after an accepted write the port is
    // closed for one cycle, limiting the write rate to one per two cycles.
    assign o_cfg_ready = w_run & ~r_acc_d;
    assign w_accept    = i_cfg_valid & o_cfg_ready;

`ifdef OSC_CE_SYNC_EN
    assign w_sync = w_run & i_sync_pulse;
`else
    assign w_sync = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Per-channel divider
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_pdiv;
        logic             r_pend;
        logic             r_ce;
        logic             w_off;
        logic             w_active;
        logic [DIV_W-1:0] w_div_m1;
        logic             w_wrap;
        logic             w_apply;
        logic             w_wr_hit;

        always_comb begin
            w_off    = (r_div == '0) | ~i_ch_en[gi];
            w_active = w_run & ~w_off;
            // Only consulted when w_active, i.e. r_div >= 1, so no underflow.
            w_div_m1 = r_div - DIV_W'(1);
            w_wrap   = w_active & (r_cnt == w_div_m1);
            // A stopped channel has no period to protect, so it takes a
            // pending divisor at once; a running one waits for a boundary.
            w_apply  = r_pend & (w_off | w_wrap | (w_active & w_sync));
            w_wr_hit = w_accept & (i_cfg_ch == CH_W'(gi));
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_div  <= DIV_W'(DEF_DIV);
                r_cnt  <= '0;
                r_pdiv <= '0;
                r_pend <= 1'b0;
                r_ce   <= 1'b0;
            end else begin
                r_ce <= w_wrap & ~w_sync;

                if (!w_active || w_wrap || w_sync) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end

                if (w_apply) begin
                    r_div  <= r_pdiv;
                    r_pend <= 1'b0;
                end
                // Placed after the apply so a write landing on the boundary
                // cycle stays pending for the next boundary.
                if (w_wr_hit) begin
                    r_pdiv <= i_cfg_div;
                    r_pend <= 1'b1;
                end
            end
        end

        assign o_ce_out[gi] = r_ce;
    end

endmodule

`default_nettype wire
